serial_alu_ctrl: RTL and testbench
==================================

Name: serial_alu_ctrl

Overview:
Bit-serial ALU sequencer. One 1-bit ALU slice, built from the team's gate cells, is time-shared across all WIDTH operand bits, trading latency for gate count. The block accepts an operation and two operands, steps the slice LSB-first for WIDTH cycles, and returns the packed result with flags. It sits between the execute-stage control and the register-file write-back path.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
op  input  3  operation code, sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  high in RUN and DONE
done  output  1  single-cycle pulse; result and flags valid
result  output  WIDTH  result register, held until next accepted start
carry_out  output  1  final carry for ADD/SUB, else 0
zero  output  1  result == 0, combinational from result register

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0, zero=1.
  - Shift registers, op, carry and bit counter are cleared.
  - Reset asserted mid-RUN aborts the operation; the partial result is discarded.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: start=1 at edge T
  - Latch a and b into shift registers, latch op.
  - carry = 1 if op is SUB/SLT/SLTU, else 0.
  - count = 0; go to RUN.
- RUN, one bit per cycle:
  - Slice sees a_sr[0], b_sr[0], carry.
  - For SUB/SLT/SLTU, b bit is inverted before the slice.
  - Slice output shifts into result shift register at the MSB end; a_sr and b_sr shift right; carry updates to the slice carry.
  - At count == WIDTH-1, also capture carry-into-MSB for overflow detection.
  - count increments; after the WIDTH-th bit go to DONE.
- DONE (cycle T+WIDTH+1):
  - done=1 for exactly one cycle; result register and carry_out updated so they are valid in this cycle.
  - Next cycle: IDLE.
- Latency: start at edge T -> done high in cycle T+WIDTH+1. Throughput: one op per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; no queuing. a, b and op may change freely after acceptance.
- Ops:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed compare. Result = {0…, N^V}, where N = MSB of difference and V = carry-into-MSB ^ carry-out.
  - 110 SLTU: result = {0…, ~carry-out}.
  - 111 reserved: result 0, carry_out 0.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - carry_out is the final slice carry for ADD/SUB; 1 on SUB means no borrow.
  - carry_out = 0 for all other ops.
  - SLT/SLTU: bits WIDTH-1..1 are forced to 0.
- zero tracks the held result register at all times, including after reset.

Test Plan:
- Reset, then ADD a=0xFFFFFFFF b=0x00000001 at T -> busy=1 T+1..T+33; done pulse at T+33; result=0x00000000, carry_out=1, zero=1.
- SUB a=5 b=7 -> result=0xFFFFFFFE, carry_out=0, zero=0. Then SUB a=7 b=7 -> result=0, carry_out=1, zero=1.
- SLT a=0x80000000 b=0x00000001 -> result=1. SLTU with the same operands -> result=0. SLT a=0x7FFFFFFF b=0xFFFFFFFF -> result=0.
- XOR a=0xA5A5A5A5 b=0xFFFF0000 -> result=0x5A5AA5A5, carry_out=0. Op 111 -> result=0.
- ADD 1+1 running; pulse start with ADD 2+2 during RUN and during the DONE cycle -> both ignored; result=2, exactly one done pulse.
- Start ADD 3+4; assert reset at cycle T+10 -> next cycle busy=0, result=0, zero=1, no done. Then ADD 3+4 -> result=7 after WIDTH+1 cycles.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice is stepped LSB-first across
// WIDTH operand bits, then the packed result and flags are published.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   start     - request, accepted only while idle
//   op        - operation code, sampled with start
//   a, b      - operands, sampled with start
//   busy      - high while running and in the done cycle
//   done      - one-cycle pulse, result and flags valid
//   result    - result register, held until the next completed op
//   carry_out - final carry for ADD/SUB, else 0
//   zero      - result == 0, decoded from the result register
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;

    logic             is_sub;
    logic             is_sub_in;
    logic             bit_a;
    logic             bit_b;
    logic             slice_sum;
    logic             slice_cout;
    logic             slice_out;
    logic             last_bit;
    logic [WIDTH-1:0] word;
    logic             ovf;

    // Subtract-type ops feed ~b with an initial carry of 1.
    assign is_sub    = (op_q == OP_SUB) || (op_q == OP_SLT) ||
                       (op_q == OP_SLTU);
    assign is_sub_in = (op == OP_SUB) || (op == OP_SLT) ||
                       (op == OP_SLTU);

    assign bit_a      = a_sr_q[0];
    assign bit_b      = b_sr_q[0] ^ is_sub;
    assign slice_sum  = bit_a ^ bit_b ^ carry_q;
    assign slice_cout = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    assign last_bit   = (count_q == CW'(WIDTH - 1));

    always_comb begin
        slice_out = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB,
            OP_SLT, OP_SLTU: slice_out = slice_sum;
            OP_AND:          slice_out = a_sr_q[0] & b_sr_q[0];
            OP_OR:           slice_out = a_sr_q[0] | b_sr_q[0];
            OP_XOR:          slice_out = a_sr_q[0] ^ b_sr_q[0];
            default:         slice_out = 1'b0;
        endcase
    end

    // On the MSB step carry_q is the carry into the MSB.
    assign word = {slice_out, r_sr_q[WIDTH-1:1]};
    assign ovf  = carry_q ^ slice_cout;

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        r_sr_d      = r_sr_q;
        op_d        = op_q;
        carry_d     = carry_q;
        count_d     = count_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    op_d    = op;
                    carry_d = is_sub_in;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                r_sr_d  = word;
                carry_d = slice_cout;
                count_d = count_q + CW'(1);
                if (last_bit) begin
                    state_d     = S_DONE;
                    carry_out_d = 1'b0;
                    result_d    = word;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            carry_out_d = slice_cout;
                        end
                        OP_SLT: begin
                            result_d = {{(WIDTH-1){1'b0}},
                                        slice_sum ^ ovf};
                        end
                        OP_SLTU: begin
                            result_d = {{(WIDTH-1){1'b0}},
                                        ~slice_cout};
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            r_sr_q      <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            r_sr_q      <= r_sr_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed ops with a scoreboard
// of model results, latency, busy/done, ignored starts and mid-run reset.
module tb_serial_alu_ctrl;

    localparam int W = 32;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] AND_ = 3'b010;
    localparam logic [2:0] OR_  = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100;
    localparam logic [2:0] SLT  = 3'b101;
    localparam logic [2:0] SLTU = 3'b110;
    localparam logic [2:0] RSV  = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t       m;
        logic [W:0] s;
        m.res  = '0;
        m.cout = 1'b0;
        s      = '0;
        case (o)
            ADD: begin
                s = {1'b0, x} + {1'b0, y};
                m.res = s[W-1:0];
                m.cout = s[W];
            end
            SUB: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                m.res = s[W-1:0];
                m.cout = s[W];
            end
            AND_: m.res = x & y;
            OR_:  m.res = x | y;
            XOR_: m.res = x ^ y;
            SLT:  m.res[0] = ($signed(x) < $signed(y));
            SLTU: m.res[0] = (x < y);
            default: ;
        endcase
        return m;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_carry"}, carry_out, e.cout);
            chk({tag, "_zero"}, zero, e.res == '0);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        bit seen;
        bit busy_ok;
        sb.push_back(model(o, x, y));
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        start = 1'b0;
        op = 3'($urandom_range(7));
        a = W'($urandom);
        b = W'($urandom);
        cyc = 1;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc <= W + 8) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                tick();
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_run"}, busy_ok, 1);
        if (seen) begin
            chk({tag, "_latency"}, cyc, W + 1);
            chk({tag, "_busy_done"}, busy, 1);
            compare_pop(tag);
        end else begin
            void'(sb.pop_front());
        end
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int dones;
        int cyc;
        bit busy_seen;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_zero", zero, 1);
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_zero", zero, 1);

        run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("sub_neg", SUB, 32'd5, 32'd7);
        run_op("sub_eq", SUB, 32'd7, 32'd7);
        run_op("slt_neg", SLT, 32'h8000_0000, 32'h0000_0001);
        run_op("sltu", SLTU, 32'h8000_0000, 32'h0000_0001);
        run_op("slt_pos", SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op("xor", XOR_, 32'hA5A5_A5A5, 32'hFFFF_0000);
        run_op("rsvd", RSV, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("and", AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op("or", OR_, 32'h0000_00F0, 32'h8000_000F);
        run_op("add_big", ADD, 32'h8000_0000, 32'h8000_0000);
        run_op("sltu_eq", SLTU, 32'h1234_5678, 32'h1234_5678);
        run_op("slt_ovf", SLT, 32'h7FFF_FFFF, 32'h8000_0000);

        // start pulses during RUN and during DONE are ignored
        sb.push_back(model(ADD, 32'd1, 32'd1));
        start = 1'b1;
        op = ADD;
        a = 32'd1;
        b = 32'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a = 32'd2;
        b = 32'd2;
        tick();
        start = 1'b0;
        chk("ign_busy", busy, 1);
        cyc = 0;
        while (!done && cyc < W + 8) begin
            tick();
            cyc++;
        end
        chk("ign_done_seen", done, 1);
        dones = done ? 1 : 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_idle", busy, 0);
        compare_pop("ign");
        busy_seen = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            if (done) dones++;
            if (busy) busy_seen = 1'b1;
            tick();
        end
        chk("ign_one_done", dones, 1);
        chk("ign_no_restart", busy_seen, 0);

        // reset mid-run discards the operation
        start = 1'b1;
        op = ADD;
        a = 32'd3;
        b = 32'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 1);
        chk("abort_done", done, 0);
        dones = 0;
        for (int i = 0; i < W + 8; i++) begin
            if (done) dones++;
            tick();
        end
        chk("abort_no_done", dones, 0);
        run_op("after_abort", ADD, 32'd3, 32'd4);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
